alu_decode_stage: RTL and testbench

- Decode stage sitting directly upstream of the execute-stage ALU.
- Accepts one fetched LoongArch32 instruction per handshake and decodes the integer ALU subset.
- Reads the register file, applies a writeback bypass, and registers the ALU operands with a valid/ready pipeline handshake.
- Produces exactly the 12-bit one-hot alu_op, alu_src1 and alu_src2 the ALU consumes, plus writeback control.

---
 rtl/alu_pkg.sv | 62 ++++++
 rtl/alu_inst_decoder.sv | 84 ++++++++
 rtl/alu_decode_stage.sv | 112 +++++++++++
 tb/tb_alu_decode_stage.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the decode stage: ALU op bit positions and
// LoongArch32 opcode field values for the supported integer subset.
package alu_pkg;

   localparam int ALU_OP_W = 12;

   // Bit positions inside the one-hot alu_op vector
   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLT  = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_AND  = 4;
   localparam int ALU_NOR  = 5;
   localparam int ALU_OR   = 6;
   localparam int ALU_XOR  = 7;
   localparam int ALU_SLL  = 8;
   localparam int ALU_SRL  = 9;
   localparam int ALU_SRA  = 10;
   localparam int ALU_MOV  = 11;

   // inst[31:15] encodings
   localparam logic [16:0] OP17_ADD_W  = 17'h00020;
   localparam logic [16:0] OP17_SUB_W  = 17'h00022;
   localparam logic [16:0] OP17_SLT    = 17'h00024;
   localparam logic [16:0] OP17_SLTU   = 17'h00025;
   localparam logic [16:0] OP17_NOR    = 17'h00028;
   localparam logic [16:0] OP17_AND    = 17'h00029;
   localparam logic [16:0] OP17_OR     = 17'h0002A;
   localparam logic [16:0] OP17_XOR    = 17'h0002B;
   localparam logic [16:0] OP17_SLL_W  = 17'h0002E;
   localparam logic [16:0] OP17_SRL_W  = 17'h0002F;
   localparam logic [16:0] OP17_SRA_W  = 17'h00030;
   localparam logic [16:0] OP17_SLLI_W = 17'h00081;
   localparam logic [16:0] OP17_SRLI_W = 17'h00089;
   localparam logic [16:0] OP17_SRAI_W = 17'h00091;

   // inst[31:22] encodings
   localparam logic [9:0] OP10_SLTI   = 10'h008;
   localparam logic [9:0] OP10_SLTUI  = 10'h009;
   localparam logic [9:0] OP10_ADDI_W = 10'h00A;
   localparam logic [9:0] OP10_ANDI   = 10'h00D;
   localparam logic [9:0] OP10_ORI    = 10'h00E;
   localparam logic [9:0] OP10_XORI   = 10'h00F;

   // inst[31:25] encodings
   localparam logic [6:0] OP7_LU12I_W = 7'h0A;

   // Where the second operand comes from; NONE doubles as "not decoded"
   typedef enum logic [2:0] {
      SRC2_NONE,
      SRC2_RK,
      SRC2_UI5,
      SRC2_SI12,
      SRC2_UI12,
      SRC2_UI20
   } src2_sel_e;

   function automatic logic [ALU_OP_W-1:0] alu_onehot(input int idx);
      return ALU_OP_W'(1) << idx;
   endfunction

endpackage

// File: rtl/alu_inst_decoder.sv
// Combinational decoder for the integer ALU subset: picks the ALU op and
// builds both operands from the (already bypassed) register values.
module alu_inst_decoder
   import alu_pkg::*;
(
   input  logic [31:0]         inst,
   input  logic [31:0]         rj_value,
   input  logic [31:0]         rk_value,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [31:0]         src1,
   output logic [31:0]         src2,
   output logic                rf_we,
   output logic [4:0]          waddr,
   output logic                invalid
);

   logic [16:0]         op17;
   logic [9:0]          op10;
   logic [6:0]          op7;
   logic [ALU_OP_W-1:0] op_sel;
   src2_sel_e           src2_sel;

   assign op17 = inst[31:15];
   assign op10 = inst[31:22];
   assign op7  = inst[31:25];

   // Opcode match; the three field groups never overlap, so later groups
   // only ever fill in when earlier ones found nothing
   always_comb begin
      op_sel   = '0;
      src2_sel = SRC2_NONE;
      case (op17)
         OP17_ADD_W:  begin op_sel = alu_onehot(ALU_ADD);  src2_sel = SRC2_RK;  end
         OP17_SUB_W:  begin op_sel = alu_onehot(ALU_SUB);  src2_sel = SRC2_RK;  end
         OP17_SLT:    begin op_sel = alu_onehot(ALU_SLT);  src2_sel = SRC2_RK;  end
         OP17_SLTU:   begin op_sel = alu_onehot(ALU_SLTU); src2_sel = SRC2_RK;  end
         OP17_NOR:    begin op_sel = alu_onehot(ALU_NOR);  src2_sel = SRC2_RK;  end
         OP17_AND:    begin op_sel = alu_onehot(ALU_AND);  src2_sel = SRC2_RK;  end
         OP17_OR:     begin op_sel = alu_onehot(ALU_OR);   src2_sel = SRC2_RK;  end
         OP17_XOR:    begin op_sel = alu_onehot(ALU_XOR);  src2_sel = SRC2_RK;  end
         OP17_SLL_W:  begin op_sel = alu_onehot(ALU_SLL);  src2_sel = SRC2_RK;  end
         OP17_SRL_W:  begin op_sel = alu_onehot(ALU_SRL);  src2_sel = SRC2_RK;  end
         OP17_SRA_W:  begin op_sel = alu_onehot(ALU_SRA);  src2_sel = SRC2_RK;  end
         OP17_SLLI_W: begin op_sel = alu_onehot(ALU_SLL);  src2_sel = SRC2_UI5; end
         OP17_SRLI_W: begin op_sel = alu_onehot(ALU_SRL);  src2_sel = SRC2_UI5; end
         OP17_SRAI_W: begin op_sel = alu_onehot(ALU_SRA);  src2_sel = SRC2_UI5; end
         default: ;
      endcase
      case (op10)
         OP10_SLTI:   begin op_sel = alu_onehot(ALU_SLT);  src2_sel = SRC2_SI12; end
         OP10_SLTUI:  begin op_sel = alu_onehot(ALU_SLTU); src2_sel = SRC2_SI12; end
         OP10_ADDI_W: begin op_sel = alu_onehot(ALU_ADD);  src2_sel = SRC2_SI12; end
         OP10_ANDI:   begin op_sel = alu_onehot(ALU_AND);  src2_sel = SRC2_UI12; end
         OP10_ORI:    begin op_sel = alu_onehot(ALU_OR);   src2_sel = SRC2_UI12; end
         OP10_XORI:   begin op_sel = alu_onehot(ALU_XOR);  src2_sel = SRC2_UI12; end
         default: ;
      endcase
      if (op7 == OP7_LU12I_W) begin
         op_sel   = alu_onehot(ALU_MOV);
         src2_sel = SRC2_UI20;
      end
   end

   // Second operand: register or one of the immediate formats
   always_comb begin
      src2 = '0;
      case (src2_sel)
         SRC2_RK:   src2 = rk_value;
         SRC2_UI5:  src2 = {27'b0, inst[14:10]};
         SRC2_SI12: src2 = {{20{inst[21]}}, inst[21:10]};
         SRC2_UI12: src2 = {20'b0, inst[21:10]};
         SRC2_UI20: src2 = {inst[24:5], 12'b0};
         default:   src2 = '0;
      endcase
   end

   // lu12i.w moves the immediate through the ALU, so rj is forced to zero
   assign invalid = (src2_sel == SRC2_NONE);
   assign src1    = (invalid || src2_sel == SRC2_UI20) ? '0 : rj_value;
   assign rf_we   = !invalid;
   assign alu_op  = op_sel;
   assign waddr   = inst[4:0];

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage ahead of the ALU: regfile read with writeback bypass,
// decode, and a single registered slot with valid/ready handshake.
module alu_decode_stage
   import alu_pkg::*;
#(
   parameter int PC_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [PC_W-1:0]     in_pc,
   input  logic [31:0]         in_inst,
   input  logic                flush,
   output logic [4:0]          rf_raddr1,
   input  logic [31:0]         rf_rdata1,
   output logic [4:0]          rf_raddr2,
   input  logic [31:0]         rf_rdata2,
   input  logic                fwd_we,
   input  logic [4:0]          fwd_waddr,
   input  logic [31:0]         fwd_wdata,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PC_W-1:0]     out_pc,
   output logic [ALU_OP_W-1:0] out_alu_op,
   output logic [31:0]         out_alu_src1,
   output logic [31:0]         out_alu_src2,
   output logic                out_rf_we,
   output logic [4:0]          out_rf_waddr,
   output logic                out_inst_invalid
);

   logic [4:0]          raddr [2];
   logic [31:0]         rdata [2];
   logic [31:0]         rvalue [2];
   logic [ALU_OP_W-1:0] dec_alu_op;
   logic [31:0]         dec_src1;
   logic [31:0]         dec_src2;
   logic                dec_rf_we;
   logic [4:0]          dec_waddr;
   logic                dec_invalid;
   logic                capture;
   logic                valid_reg;
   logic                valid_next;

   assign raddr[0]  = in_inst[9:5];
   assign raddr[1]  = in_inst[14:10];
   assign rdata[0]  = rf_rdata1;
   assign rdata[1]  = rf_rdata2;
   assign rf_raddr1 = raddr[0];
   assign rf_raddr2 = raddr[1];

   // r0 is hardwired to zero even if writeback targets it
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bypass
         assign rvalue[gi] = (raddr[gi] == 5'd0) ? 32'd0 :
                             (fwd_we && fwd_waddr == raddr[gi]) ? fwd_wdata : rdata[gi];
      end
   endgenerate

   alu_inst_decoder u_decoder (
      .inst     (in_inst),
      .rj_value (rvalue[0]),
      .rk_value (rvalue[1]),
      .alu_op   (dec_alu_op),
      .src1     (dec_src1),
      .src2     (dec_src2),
      .rf_we    (dec_rf_we),
      .waddr    (dec_waddr),
      .invalid  (dec_invalid)
   );

   assign in_ready = !valid_reg || out_ready;
   assign capture  = in_valid && in_ready && !flush;

   // Valid tracking: flush wins, then a new capture, then drain on accept
   always_comb begin
      valid_next = valid_reg;
      if (flush)          valid_next = 1'b0;
      else if (capture)   valid_next = 1'b1;
      else if (out_ready) valid_next = 1'b0;
   end

   // Pipeline register; payload only moves on capture so it holds under backpressure
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_reg        <= 1'b0;
         out_pc           <= '0;
         out_alu_op       <= '0;
         out_alu_src1     <= '0;
         out_alu_src2     <= '0;
         out_rf_we        <= 1'b0;
         out_rf_waddr     <= '0;
         out_inst_invalid <= 1'b0;
      end else begin
         valid_reg <= valid_next;
         if (capture) begin
            out_pc           <= in_pc;
            out_alu_op       <= dec_alu_op;
            out_alu_src1     <= dec_src1;
            out_alu_src2     <= dec_src2;
            out_rf_we        <= dec_rf_we;
            out_rf_waddr     <= dec_waddr;
            out_inst_invalid <= dec_invalid;
         end
      end
   end

   assign out_valid = valid_reg;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage with a reference decoder and scoreboard.
module tb_alu_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, flush;
   logic [31:0] in_pc, in_inst;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic        fwd_we;
   logic [4:0]  fwd_waddr;
   logic [31:0] fwd_wdata;
   logic        out_valid, out_ready;
   logic [31:0] out_pc;
   logic [11:0] out_alu_op;
   logic [31:0] out_alu_src1, out_alu_src2;
   logic        out_rf_we;
   logic [4:0]  out_rf_waddr;
   logic        out_inst_invalid;

   logic [31:0] regs [32];

   typedef struct packed {
      logic [31:0] pc;
      logic [11:0] op;
      logic [31:0] s1;
      logic [31:0] s2;
      logic        we;
      logic [4:0]  wa;
      logic        inv;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   assign rf_rdata1 = regs[rf_raddr1];
   assign rf_rdata2 = regs[rf_raddr2];

   alu_decode_stage #(.PC_W(32)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
      .flush(flush),
      .rf_raddr1(rf_raddr1), .rf_rdata1(rf_rdata1),
      .rf_raddr2(rf_raddr2), .rf_rdata2(rf_rdata2),
      .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_alu_op(out_alu_op), .out_alu_src1(out_alu_src1), .out_alu_src2(out_alu_src2),
      .out_rf_we(out_rf_we), .out_rf_waddr(out_rf_waddr), .out_inst_invalid(out_inst_invalid)
   );

   function automatic logic [31:0] rd_val(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (fwd_we && fwd_waddr == r) return fwd_wdata;
      return regs[r];
   endfunction

   // Reference decode written straight from the opcode table
   function automatic exp_t model(input logic [31:0] pc, input logic [31:0] inst);
      exp_t        e;
      logic [31:0] a, b;
      int          idx, kind;   // kind: 0 none, 1 rk, 2 ui5, 3 si12, 4 ui12, 5 lu12i
      a = rd_val(inst[9:5]);
      b = rd_val(inst[14:10]);
      idx = -1;
      kind = 0;
      case (inst[31:15])
         17'h00020: begin idx = 0;  kind = 1; end
         17'h00022: begin idx = 1;  kind = 1; end
         17'h00024: begin idx = 2;  kind = 1; end
         17'h00025: begin idx = 3;  kind = 1; end
         17'h00028: begin idx = 5;  kind = 1; end
         17'h00029: begin idx = 4;  kind = 1; end
         17'h0002A: begin idx = 6;  kind = 1; end
         17'h0002B: begin idx = 7;  kind = 1; end
         17'h0002E: begin idx = 8;  kind = 1; end
         17'h0002F: begin idx = 9;  kind = 1; end
         17'h00030: begin idx = 10; kind = 1; end
         17'h00081: begin idx = 8;  kind = 2; end
         17'h00089: begin idx = 9;  kind = 2; end
         17'h00091: begin idx = 10; kind = 2; end
         default: ;
      endcase
      case (inst[31:22])
         10'h008: begin idx = 2; kind = 3; end
         10'h009: begin idx = 3; kind = 3; end
         10'h00A: begin idx = 0; kind = 3; end
         10'h00D: begin idx = 4; kind = 4; end
         10'h00E: begin idx = 6; kind = 4; end
         10'h00F: begin idx = 7; kind = 4; end
         default: ;
      endcase
      if (inst[31:25] == 7'h0A) begin idx = 11; kind = 5; end
      e.pc  = pc;
      e.wa  = inst[4:0];
      e.inv = (idx < 0);
      e.we  = (idx >= 0);
      e.op  = (idx < 0) ? 12'd0 : (12'd1 << idx);
      e.s1  = (kind >= 1 && kind <= 4) ? a : 32'd0;
      case (kind)
         1:       e.s2 = b;
         2:       e.s2 = {27'd0, inst[14:10]};
         3:       e.s2 = {{20{inst[21]}}, inst[21:10]};
         4:       e.s2 = {20'd0, inst[21:10]};
         5:       e.s2 = {inst[24:5], 12'd0};
         default: e.s2 = 32'd0;
      endcase
      return e;
   endfunction

   function automatic exp_t observe();
      exp_t o;
      o.pc = out_pc; o.op = out_alu_op; o.s1 = out_alu_src1; o.s2 = out_alu_src2;
      o.we = out_rf_we; o.wa = out_rf_waddr; o.inv = out_inst_invalid;
      return o;
   endfunction

   // One clock: record the expected result of any capture, end at posedge+1
   task automatic tick();
      @(negedge clk);
      if (in_valid && in_ready && !flush && !reset) sb.push_back(model(in_pc, in_inst));
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_vec++; if (observe() !== exp_t'(0)) begin n_bad++; $display("FAIL reset_payload: got %h want 0", observe()); end
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_known_vectors();
      logic [31:0] kinst [6];
      exp_t        ktab [6];
      exp_t        exp, got;
      int          k;
      kinst[0] = 32'h00100823; kinst[1] = 32'h02BFFC24; kinst[2] = 32'h03BFFC06;
      kinst[3] = 32'h142468A5; kinst[4] = 32'h00488C27; kinst[5] = 32'hFFFFFFFF;
      ktab[0] = {32'h1c000000, 12'h001, 32'd5, 32'd7,          1'b1, 5'd3,  1'b0};
      ktab[1] = {32'h1c000004, 12'h001, 32'd5, 32'hFFFFFFFF,   1'b1, 5'd4,  1'b0};
      ktab[2] = {32'h1c000008, 12'h040, 32'd0, 32'h00000FFF,   1'b1, 5'd6,  1'b0};
      ktab[3] = {32'h1c00000c, 12'h800, 32'd0, 32'h12345000,   1'b1, 5'd5,  1'b0};
      ktab[4] = {32'h1c000010, 12'h400, 32'd5, 32'd3,          1'b1, 5'd7,  1'b0};
      ktab[5] = {32'h1c000014, 12'h000, 32'd0, 32'd0,          1'b0, 5'd31, 1'b1};
      regs[0] = 32'hBAD00000; regs[1] = 32'd5; regs[2] = 32'd7;
      out_ready = 1'b1;
      k = 0;
      for (int i = 0; i <= 6; i++) begin
         if (i < 6) begin
            in_valid = 1'b1; in_inst = kinst[i]; in_pc = 32'h1c000000 + 32'(4 * i);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (i > 0) begin
            n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL known_throughput[%0d]: got %b want 1", i, out_valid); end
         end
         if (out_valid && out_ready && k < 6) begin
            got = observe();
            n_vec++; if (got !== ktab[k]) begin n_bad++; $display("FAIL known[%0d]: got %h want %h", k, got, ktab[k]); end
            if (sb.size() == 0) begin
               n_vec++; n_bad++; $display("FAIL known_sb[%0d]: got output %h want none", k, got);
            end else begin
               exp = sb.pop_front();
               n_vec++; if (got !== exp) begin n_bad++; $display("FAIL known_model[%0d]: got %h want %h", k, got, exp); end
            end
            k++;
         end
         tick();
      end
      n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL known_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_all_ops();
      logic [31:0] insts[$];
      logic [16:0] t17 [17];
      logic [9:0]  t10 [7];
      exp_t        exp, got;
      int          j, cyc;
      bit          acc;
      t17 = '{17'h20, 17'h22, 17'h24, 17'h25, 17'h28, 17'h29, 17'h2A, 17'h2B, 17'h2E,
              17'h2F, 17'h30, 17'h81, 17'h89, 17'h91, 17'h21, 17'h31, 17'h00};
      t10 = '{10'h008, 10'h009, 10'h00A, 10'h00D, 10'h00E, 10'h00F, 10'h00B};
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      repeat (2) begin
         foreach (t17[i]) insts.push_back({t17[i], 15'($urandom)});
         foreach (t10[i]) insts.push_back({t10[i], 22'($urandom)});
         insts.push_back({7'h0A, 25'($urandom)});
         insts.push_back({7'h0B, 25'($urandom)});
      end
      j = 0;
      cyc = 0;
      while (j < insts.size() && cyc < 2000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_inst   = insts[j];
         in_pc     = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         fwd_we    = 1'($urandom_range(0, 1));
         fwd_waddr = ($urandom_range(0, 1) != 0) ? insts[j][9:5] : insts[j][14:10];
         fwd_wdata = $urandom;
         #1;
         if (out_valid && out_ready) begin
            got = observe();
            if (sb.size() == 0) begin
               n_vec++; n_bad++; $display("FAIL all_ops_sb: got output %h want none", got);
            end else begin
               exp = sb.pop_front();
               n_vec++; if (got !== exp) begin n_bad++; $display("FAIL all_ops[%0d]: got %h want %h", j, got, exp); end
            end
         end
         acc = in_valid && in_ready;
         tick();
         if (acc) j++;
         cyc++;
      end
      n_vec++; if (j != insts.size()) begin n_bad++; $display("FAIL all_ops_timeout: got %0d accepted want %0d", j, insts.size()); end
      in_valid = 1'b0; out_ready = 1'b1; fwd_we = 1'b0;
      repeat (3) begin
         #1;
         if (out_valid && out_ready) begin
            got = observe();
            if (sb.size() == 0) begin
               n_vec++; n_bad++; $display("FAIL all_ops_drain_sb: got output %h want none", got);
            end else begin
               exp = sb.pop_front();
               n_vec++; if (got !== exp) begin n_bad++; $display("FAIL all_ops_drain: got %h want %h", got, exp); end
            end
         end
         tick();
      end
      n_vec++; if (sb.size() != 0) begin n_bad++; $display("FAIL all_ops_left: got %0d pending want 0", sb.size()); end
   endtask

   task automatic test_bypass();
      logic [31:0] binst [3];
      logic [4:0]  bwa [3];
      logic [31:0] bs1 [3];
      logic [31:0] bs2 [3];
      exp_t        exp, got;
      binst[0] = 32'h00100823; bwa[0] = 5'd1; bs1[0] = 32'hDEAD0000; bs2[0] = 32'd7;
      binst[1] = 32'h00100803; bwa[1] = 5'd0; bs1[1] = 32'd0;        bs2[1] = 32'd7;
      binst[2] = 32'h00100823; bwa[2] = 5'd2; bs1[2] = 32'd5;        bs2[2] = 32'hDEAD0000;
      regs[0] = 32'h12345678; regs[1] = 32'd5; regs[2] = 32'd7;
      out_ready = 1'b1; fwd_we = 1'b1; fwd_wdata = 32'hDEAD0000;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_inst = binst[i]; in_pc = 32'h1c000100 + 32'(4 * i); fwd_waddr = bwa[i];
         tick();
         in_valid = 1'b0;
         #1;
         got = observe();
         n_vec++; if (out_alu_src1 !== bs1[i]) begin n_bad++; $display("FAIL bypass_src1[%0d]: got %h want %h", i, out_alu_src1, bs1[i]); end
         n_vec++; if (out_alu_src2 !== bs2[i]) begin n_bad++; $display("FAIL bypass_src2[%0d]: got %h want %h", i, out_alu_src2, bs2[i]); end
         if (sb.size() == 0) begin
            n_vec++; n_bad++; $display("FAIL bypass_sb[%0d]: got output %h want none", i, got);
         end else begin
            exp = sb.pop_front();
            n_vec++; if (got !== exp) begin n_bad++; $display("FAIL bypass_model[%0d]: got %h want %h", i, got, exp); end
         end
         tick();
      end
      fwd_we = 1'b0;
   endtask

   task automatic test_backpressure();
      exp_t exp, got;
      regs[1] = 32'h0F0F0F0F; regs[2] = 32'h00FF00FF;
      out_ready = 1'b0; in_valid = 1'b1; in_inst = {17'h2B, 5'd2, 5'd1, 5'd8}; in_pc = 32'h1c000200;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_empty: got %b want 1", in_ready); end
      tick();
      in_inst = 32'hFFFFFFFF; in_pc = 32'h1c000204;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
         n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", c, out_valid); end
         n_vec++; if (sb.size() != 1 || observe() !== sb[0]) begin n_bad++; $display("FAIL bp_hold[%0d]: got %h want held payload, %0d pending", c, observe(), sb.size()); end
         tick();
      end
      out_ready = 1'b1;
      #1;
      got = observe();
      exp = (sb.size() != 0) ? sb.pop_front() : exp_t'(0);
      n_vec++; if (!out_valid || got !== exp) begin n_bad++; $display("FAIL bp_release: got valid=%b %h want valid=1 %h", out_valid, got, exp); end
      tick();
      in_valid = 1'b0;
      #1;
      got = observe();
      exp = (sb.size() != 0) ? sb.pop_front() : exp_t'(0);
      n_vec++; if (!out_valid || got !== exp) begin n_bad++; $display("FAIL bp_second: got valid=%b %h want valid=1 %h", out_valid, got, exp); end
      n_vec++; if ({out_inst_invalid, out_rf_we, out_alu_op} !== {1'b1, 1'b0, 12'h000}) begin
         n_bad++; $display("FAIL bp_invalid_inst: got inv=%b we=%b op=%h want inv=1 we=0 op=000", out_inst_invalid, out_rf_we, out_alu_op);
      end
      tick();
      n_vec++; if (out_valid !== 1'b0 || sb.size() != 0) begin n_bad++; $display("FAIL bp_single_transfer: got valid=%b pending=%0d want 0/0", out_valid, sb.size()); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00100823; in_pc = 32'h1c000300;
      tick();
      n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_setup: got %b want 1", out_valid); end
      in_inst = 32'h02BFFC24; flush = 1'b1;
      tick();
      sb.delete();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_kill: got %b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b want 1", in_ready); end
      out_ready = 1'b1; in_valid = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b0 || sb.size() != 0) begin n_bad++; $display("FAIL flush_drop_capture: got valid=%b pending=%0d want 0/0", out_valid, sb.size()); end
   endtask

   task automatic test_async_reset();
      exp_t exp, got;
      out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h00488C27; in_pc = 32'h1c000400;
      tick();
      #1;
      reset = 1'b1;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL async_reset_valid: got %b want 0", out_valid); end
      n_vec++; if (observe() !== exp_t'(0)) begin n_bad++; $display("FAIL async_reset_payload: got %h want 0", observe()); end
      in_valid = 1'b0;
      sb.delete();
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid: got %b want 0", out_valid); end
      in_valid = 1'b1; in_inst = 32'h142468A5; in_pc = 32'h1c000500;
      tick();
      in_valid = 1'b0;
      #1;
      got = observe();
      exp = (sb.size() != 0) ? sb.pop_front() : exp_t'(0);
      n_vec++; if (!out_valid || got !== exp) begin n_bad++; $display("FAIL post_reset_xfer: got valid=%b %h want valid=1 %h", out_valid, got, exp); end
      tick();
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; flush = 1'b0;
      fwd_we = 1'b0; fwd_waddr = '0; fwd_wdata = '0; out_ready = 1'b0;
      for (int i = 0; i < 32; i++) regs[i] = 32'h0;
      test_reset();
      test_known_vectors();
      test_all_ops();
      test_bypass();
      test_backpressure();
      test_flush();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
